// File: rtl/smvm_stream_encoder.sv
// Dense-to-sparse encoder: buffers one matrix and vector, then emits the SMVM input burst.
// Optional macro SMVM_ENC_ZERO_ROW_EN: empty rows emit a single zero pair with the row-start flag.
//
// state     | meaning
// IDLE      | wait for a legal configuration strobe
// LOAD      | accept vector then row-major matrix beats
// TX_ROWS   | stream row count
// TX_COLS   | stream column count
// TX_VEC    | stream vector elements
// TX_VAL    | stream nonzero value with row-start flag
// TX_IDX    | stream column index of that value
// FIN       | pulse done, back to IDLE
module smvm_stream_encoder #(
  parameter int MAX_DIM = 8,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  input  logic [3:0]    cfg_rows,
  input  logic [3:0]    cfg_cols,
  output logic          cfg_err,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] enc_val,
  output logic [2:0]    enc_col,
  output logic          enc_ipv,
  output logic          enc_valid,
  output logic          busy,
  output logic          done
);

  localparam int NCELL = MAX_DIM * MAX_DIM;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TX_ROWS, S_TX_COLS, S_TX_VEC, S_TX_VAL, S_TX_IDX, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       rows_q, rows_d, cols_q, cols_d;
  logic [2:0]       r_q, r_d, c_q, c_d;
  logic             vec_ph_q, vec_ph_d;
  logic [5:0]       pos_q, pos_d;
  logic [NCELL-1:0] mask_q, mask_d, eff_mask;
  logic [DW-1:0]    enc_val_q, enc_val_d;
  logic [2:0]       enc_col_q, enc_col_d;
  logic             enc_ipv_q, enc_ipv_d, enc_valid_q, enc_valid_d;
  logic             ld_ready_q, ld_ready_d, busy_q, busy_d;
  logic             done_q, done_d, cfg_err_q, cfg_err_d;

  logic [DW-1:0]    vec_mem [MAX_DIM];
  logic [DW-1:0]    mat_mem [NCELL];
  logic             vec_we, mat_we, cfg_legal, found;
  logic [6:0]       srch_from;
  logic [5:0]       found_pos;
  logic [2:0]       vec_nxt;

  // In the zero-row build an empty in-range row looks like a nonzero at column 0.
  always_comb begin
    eff_mask = mask_q;
`ifdef SMVM_ENC_ZERO_ROW_EN
    for (int r = 0; r < MAX_DIM; r++) begin
      if ((4'(r) < rows_q) && (mask_q[r*MAX_DIM +: MAX_DIM] == '0)) eff_mask[r*MAX_DIM] = 1'b1;
    end
`endif
  end

  // Lowest set bit at row-major position >= srch_from; crossing rows is free.
  always_comb begin
    srch_from = (state_q == S_TX_IDX) ? ({1'b0, pos_q} + 7'd1) : 7'd0;
    found     = 1'b0;
    found_pos = '0;
    for (int i = NCELL - 1; i >= 0; i--) begin
      if (eff_mask[i] && (7'(i) >= srch_from)) begin
        found     = 1'b1;
        found_pos = 6'(i);
      end
    end
  end

  assign cfg_legal = (cfg_rows != 4'd0) && (cfg_rows <= 4'd8) &&
                     (cfg_cols != 4'd0) && (cfg_cols <= 4'd8);
  assign vec_nxt   = c_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    r_d         = r_q;
    c_d         = c_q;
    vec_ph_d    = vec_ph_q;
    pos_d       = pos_q;
    mask_d      = mask_q;
    enc_val_d   = '0;
    enc_col_d   = '0;
    enc_ipv_d   = 1'b0;
    enc_valid_d = 1'b0;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    vec_we      = 1'b0;
    mat_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          if (cfg_legal) begin
            rows_d   = cfg_rows;
            cols_d   = cfg_cols;
            mask_d   = '0;
            r_d      = '0;
            c_d      = '0;
            vec_ph_d = 1'b1;
            state_d  = S_LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (ld_valid && ld_ready_q) begin
          if (vec_ph_q) begin
            vec_we = 1'b1;
            if ({1'b0, c_q} == cols_q - 4'd1) begin
              c_d      = '0;
              vec_ph_d = 1'b0;
            end else begin
              c_d = c_q + 3'd1;
            end
          end else begin
            mat_we              = 1'b1;
            mask_d[{r_q, c_q}] = |ld_data;
            if ({1'b0, c_q} == cols_q - 4'd1) begin
              c_d = '0;
              if ({1'b0, r_q} == rows_q - 4'd1) begin
                state_d     = S_TX_ROWS;
                enc_val_d   = DW'(rows_q);
                enc_valid_d = 1'b1;
              end else begin
                r_d = r_q + 3'd1;
              end
            end else begin
              c_d = c_q + 3'd1;
            end
          end
        end
      end
      S_TX_ROWS: begin
        state_d     = S_TX_COLS;
        enc_val_d   = DW'(cols_q);
        enc_valid_d = 1'b1;
      end
      S_TX_COLS: begin
        state_d     = S_TX_VEC;
        c_d         = '0;
        enc_val_d   = vec_mem[0];
        enc_valid_d = 1'b1;
      end
      S_TX_VEC, S_TX_IDX: begin
        if ((state_q == S_TX_VEC) && ({1'b0, c_q} != cols_q - 4'd1)) begin
          c_d         = vec_nxt;
          enc_val_d   = vec_mem[vec_nxt];
          enc_valid_d = 1'b1;
        end else if (found) begin
          state_d     = S_TX_VAL;
          pos_d       = found_pos;
          enc_val_d   = mat_mem[found_pos];
          enc_ipv_d   = (state_q == S_TX_VEC) || (found_pos[5:3] != pos_q[5:3]);
          enc_valid_d = 1'b1;
        end else begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end
      end
      S_TX_VAL: begin
        state_d     = S_TX_IDX;
        enc_col_d   = pos_q[2:0];
        enc_valid_d = 1'b1;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d     = (state_d != S_IDLE);
    ld_ready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      r_q         <= '0;
      c_q         <= '0;
      vec_ph_q    <= 1'b0;
      pos_q       <= '0;
      mask_q      <= '0;
      enc_val_q   <= '0;
      enc_col_q   <= '0;
      enc_ipv_q   <= 1'b0;
      enc_valid_q <= 1'b0;
      ld_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      r_q         <= r_d;
      c_q         <= c_d;
      vec_ph_q    <= vec_ph_d;
      pos_q       <= pos_d;
      mask_q      <= mask_d;
      enc_val_q   <= enc_val_d;
      enc_col_q   <= enc_col_d;
      enc_ipv_q   <= enc_ipv_d;
      enc_valid_q <= enc_valid_d;
      ld_ready_q  <= ld_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Payload storage needs no reset; only mask-qualified cells are ever read.
  always_ff @(posedge clk) begin
    if (vec_we) vec_mem[c_q] <= ld_data;
    if (mat_we) mat_mem[{r_q, c_q}] <= ld_data;
  end

  assign enc_val   = enc_val_q;
  assign enc_col   = enc_col_q;
  assign enc_ipv   = enc_ipv_q;
  assign enc_valid = enc_valid_q;
  assign ld_ready  = ld_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_smvm_stream_encoder.sv
// Directed bench for smvm_stream_encoder; expected streams are hand-derived beat lists.
module tb_smvm_stream_encoder;

  logic       clk, rst_n;
  logic       cfg_valid, cfg_err;
  logic [3:0] cfg_rows, cfg_cols;
  logic       ld_valid, ld_ready;
  logic [7:0] ld_data, enc_val;
  logic [2:0] enc_col;
  logic       enc_ipv, enc_valid, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  ld_q[$];
  logic [11:0] got_q[$];
  logic [11:0] exp_q[$];

  smvm_stream_encoder #(.MAX_DIM(8), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_err(cfg_err),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .enc_val(enc_val), .enc_col(enc_col), .enc_ipv(enc_ipv), .enc_valid(enc_valid),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bt(input int v, input int c, input int p);
    return {8'(v), 3'(c), 1'(p)};
  endfunction

  task automatic do_cfg(input int rows, input int cols);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_rows  = 4'(rows);
    cfg_cols  = 4'(cols);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic load(input bit gaps);
    for (int i = 0; i < ld_q.size(); i++) begin
      if (gaps && i > 0) begin
        ld_valid = 1'b0;
        ld_data  = 8'hAA;
        @(negedge clk);
      end
      ld_valid = 1'b1;
      ld_data  = ld_q[i];
      @(negedge clk);
    end
    ld_valid = 1'b0;
  endtask

  task automatic capture(input string tag, input bit cfg_noise);
    int waitc = 0;
    got_q.delete();
    ld_valid = 1'b0;
    while (!enc_valid && waitc < 20) begin
      waitc++;
      @(negedge clk);
    end
    chk({tag, " first_beat_latency"}, 32'(waitc), 32'd0);
    if (cfg_noise) begin
      cfg_valid = 1'b1;
      cfg_rows  = 4'd2;
      cfg_cols  = 4'd2;
    end
    while (enc_valid && got_q.size() < 300) begin
      got_q.push_back({enc_val, enc_col, enc_ipv});
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    chk({tag, " done_after_burst"}, 32'(done), 32'd1);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, " busy_back_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, " burst_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic setup_2x2();
    ld_q  = '{8'd3, 8'hFF, 8'd5, 8'd0, 8'd0, 8'hFE};
    exp_q = '{bt(2,0,0), bt(2,0,0), bt(3,0,0), bt(-1,0,0),
              bt(5,0,1), bt(0,0,0), bt(-2,0,1), bt(0,1,0)};
  endtask

  task automatic setup_3x8();
    ld_q.delete();
    for (int i = 0; i < 8; i++) ld_q.push_back(8'(i + 1));
    for (int i = 0; i < 24; i++) ld_q.push_back(8'd0);
    ld_q[8 + 2]  = 8'd7;
    ld_q[24 + 0] = 8'hFD;
    ld_q[24 + 7] = 8'd4;
    exp_q.delete();
    exp_q.push_back(bt(3,0,0));
    exp_q.push_back(bt(8,0,0));
    for (int i = 0; i < 8; i++) exp_q.push_back(bt(i + 1, 0, 0));
    exp_q.push_back(bt(7,0,1));
    exp_q.push_back(bt(0,2,0));
`ifdef SMVM_ENC_ZERO_ROW_EN
    exp_q.push_back(bt(0,0,1));
    exp_q.push_back(bt(0,0,0));
`endif
    exp_q.push_back(bt(-3,0,1));
    exp_q.push_back(bt(0,0,0));
    exp_q.push_back(bt(4,0,0));
    exp_q.push_back(bt(0,7,0));
  endtask

  initial begin
    int ipv_n, ipv_c0;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_rows = '0; cfg_cols = '0;
    ld_valid = 1'b0; ld_data = '0;
    repeat (3) @(negedge clk);
    chk("rst enc_valid", 32'(enc_valid), 32'd0);
    chk("rst enc_val", 32'(enc_val), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ld_ready", 32'(ld_ready), 32'd0);
    chk("rst done_cfg_err", 32'({done, cfg_err, enc_ipv, enc_col}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_cfg(0, 2);
    chk("rows0 cfg_err", 32'(cfg_err), 32'd1);
    chk("rows0 busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rows0 cfg_err_pulse", 32'(cfg_err), 32'd0);
    do_cfg(2, 9);
    chk("cols9 cfg_err", 32'(cfg_err), 32'd1);
    chk("cols9 busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("cols9 cfg_err_pulse", 32'(cfg_err), 32'd0);

    do_cfg(2, 2);
    chk("2x2 ld_ready", 32'(ld_ready), 32'd1);
    chk("2x2 cfg_err_quiet", 32'(cfg_err), 32'd0);
    setup_2x2();
    load(1'b0);
    capture("2x2", 1'b0);
    cmp_stream("2x2");

    do_cfg(2, 2);
    load(1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst in_tx_vec", 32'({enc_valid, enc_val}), 32'({1'b1, 8'd3}));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst enc_valid", 32'(enc_valid), 32'd0);
    chk("midrst enc_val", 32'(enc_val), 32'd0);
    chk("midrst busy_ready_done", 32'({busy, ld_ready, done, enc_ipv, enc_col}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst busy", 32'(busy), 32'd0);
    do_cfg(2, 2);
    chk("postrst ld_ready", 32'(ld_ready), 32'd1);
    load(1'b0);
    capture("2x2_cfgnoise", 1'b1);
    cmp_stream("2x2_cfgnoise");

    do_cfg(3, 8);
    setup_3x8();
    load(1'b0);
    capture("3x8", 1'b0);
    cmp_stream("3x8");

    do_cfg(3, 8);
    load(1'b1);
    capture("3x8_gap", 1'b0);
    cmp_stream("3x8_gap");

    do_cfg(8, 8);
    ld_q.delete();
    exp_q.delete();
    exp_q.push_back(bt(8,0,0));
    exp_q.push_back(bt(8,0,0));
    for (int i = 0; i < 8; i++) begin
      ld_q.push_back(8'(-(i + 1)));
      exp_q.push_back(bt(-(i + 1), 0, 0));
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ld_q.push_back(8'(r * 8 + c + 1));
        exp_q.push_back(bt(r * 8 + c + 1, 0, (c == 0) ? 1 : 0));
        exp_q.push_back(bt(0, c, 0));
      end
    load(1'b0);
    capture("dense", 1'b0);
    cmp_stream("dense");
    ipv_n = 0;
    ipv_c0 = 0;
    for (int i = 0; i + 1 < got_q.size(); i++)
      if (got_q[i][0]) begin
        ipv_n++;
        if (got_q[i+1][3:1] == 3'd0) ipv_c0++;
      end
    chk("dense ipv_count", 32'(ipv_n), 32'd8);
    chk("dense ipv_at_col0", 32'(ipv_c0), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
